// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one single-cycle ALU between two valid/ready requesters.
// Optional macro ALU_SHARE_ILLEGAL_CHECK_EN adds rsp0_err/rsp1_err for illegal ALU function codes.
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int FUN_W = 6
) (
  input  logic             clk,
  input  logic             reset,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_sign,
  input  logic [FUN_W-1:0] req0_fun,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_data,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_sign,
  input  logic [FUN_W-1:0] req1_fun,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_data,

`ifdef ALU_SHARE_ILLEGAL_CHECK_EN
  output logic             rsp0_err,
  output logic             rsp1_err,
`endif

  output logic [WIDTH-1:0] alu_inA,
  output logic [WIDTH-1:0] alu_inB,
  output logic             alu_Sign,
  output logic [FUN_W-1:0] alu_ALUFun,
  input  logic [WIDTH-1:0] alu_outZ
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic             last_grant;
  logic             owner;
  logic             any_valid;
  logic             grant_id;
  logic             grant_open;
  logic             owner_taken;
  logic [WIDTH-1:0] result;

  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_grant;
    end else begin
      grant_id = req1_valid;
    end
    // ready is also masked while reset is held so outputs read 0 immediately
    grant_open  = reset && (state == IDLE) && any_valid;
    req0_ready  = grant_open && !grant_id;
    req1_ready  = grant_open && grant_id;
    owner_taken = owner ? rsp1_ready : rsp0_ready;
  end

`ifdef ALU_SHARE_ILLEGAL_CHECK_EN
  logic fun_bad;

  always_comb begin
    fun_bad = 1'b1;
    case (alu_ALUFun)
      FUN_W'(6'b000000), FUN_W'(6'b000001),
      FUN_W'(6'b011000), FUN_W'(6'b011110), FUN_W'(6'b010110),
      FUN_W'(6'b010001), FUN_W'(6'b011010),
      FUN_W'(6'b100000), FUN_W'(6'b100001), FUN_W'(6'b100011),
      FUN_W'(6'b110001), FUN_W'(6'b110011), FUN_W'(6'b110101),
      FUN_W'(6'b111101), FUN_W'(6'b111011), FUN_W'(6'b111111): fun_bad = 1'b0;
      default: fun_bad = 1'b1;
    endcase
    result = fun_bad ? '0 : alu_outZ;
  end
`else
  always_comb begin
    result = alu_outZ;
  end
`endif

  // alu_* double as the operand registers: loaded at grant, stable through EXEC
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      owner      <= 1'b0;
      alu_inA    <= '0;
      alu_inB    <= '0;
      alu_Sign   <= 1'b0;
      alu_ALUFun <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_data  <= '0;
      rsp1_data  <= '0;
`ifdef ALU_SHARE_ILLEGAL_CHECK_EN
      rsp0_err   <= 1'b0;
      rsp1_err   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            owner      <= grant_id;
            last_grant <= grant_id;
            alu_inA    <= grant_id ? req1_a    : req0_a;
            alu_inB    <= grant_id ? req1_b    : req0_b;
            alu_Sign   <= grant_id ? req1_sign : req0_sign;
            alu_ALUFun <= grant_id ? req1_fun  : req0_fun;
            state      <= EXEC;
          end
        end
        EXEC: begin
          if (owner) begin
            rsp1_valid <= 1'b1;
            rsp1_data  <= result;
`ifdef ALU_SHARE_ILLEGAL_CHECK_EN
            rsp1_err   <= fun_bad;
`endif
          end else begin
            rsp0_valid <= 1'b1;
            rsp0_data  <= result;
`ifdef ALU_SHARE_ILLEGAL_CHECK_EN
            rsp0_err   <= fun_bad;
`endif
          end
          state <= RESP;
        end
        RESP: begin
          if (owner_taken) begin
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
`ifdef ALU_SHARE_ILLEGAL_CHECK_EN
            rsp0_err   <= 1'b0;
            rsp1_err   <= 1'b0;
`endif
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed scoreboard bench for alu_share_arbiter with a behavioural ALU on alu_outZ.
// Inputs change #1 after posedge; DUT outputs and response handshakes are sampled on negedge.
module tb_alu_share_arbiter;
  localparam int WIDTH = 32;
  localparam int FUN_W = 6;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready, req0_sign, rsp0_valid, rsp0_ready;
  logic             req1_valid, req1_ready, req1_sign, rsp1_valid, rsp1_ready;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b, rsp0_data, rsp1_data;
  logic [FUN_W-1:0] req0_fun, req1_fun, alu_ALUFun;
  logic [WIDTH-1:0] alu_inA, alu_inB, alu_outZ;
  logic             alu_Sign;
`ifdef ALU_SHARE_ILLEGAL_CHECK_EN
  logic             rsp0_err, rsp1_err;
`endif

  typedef struct packed {
    logic        owner;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_exp;
  int          checks = 0;
  int          errors = 0;
  logic        mon_own;
  logic [31:0] mon_data;
  logic        mon_err;

  always #5 clk = ~clk;

  alu_share_arbiter #(.WIDTH(WIDTH), .FUN_W(FUN_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_sign(req0_sign), .req0_fun(req0_fun),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_sign(req1_sign), .req1_fun(req1_fun),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
`ifdef ALU_SHARE_ILLEGAL_CHECK_EN
    .rsp0_err(rsp0_err), .rsp1_err(rsp1_err),
`endif
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_Sign(alu_Sign), .alu_ALUFun(alu_ALUFun),
    .alu_outZ(alu_outZ)
  );

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic s, input logic [5:0] f);
    logic lt;
    lt = s ? ($signed(a) < $signed(b)) : (a < b);
    case (f)
      6'b000000: return a + b;
      6'b000001: return a - b;
      6'b011000: return a & b;
      6'b011110: return a | b;
      6'b010110: return a ^ b;
      6'b010001: return ~(a | b);
      6'b011010: return a;
      6'b100000: return b << a[4:0];
      6'b100001: return b >> a[4:0];
      6'b100011: return $unsigned($signed(b) >>> a[4:0]);
      6'b110001: return {31'b0, a != b};
      6'b110011: return {31'b0, a == b};
      6'b110101: return {31'b0, lt};
      6'b111101: return {31'b0, a[31] | (a == 32'b0)};
      6'b111011: return {31'b0, a[31]};
      6'b111111: return {31'b0, !a[31] && (a != 32'b0)};
      default:   return 32'hDEAD_BEEF;
    endcase
  endfunction

  always_comb alu_outZ = alu_model(alu_inA, alu_inB, alu_Sign, alu_ALUFun);

  // scoreboard: every accepted response must match the oldest expected entry
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (rsp0_valid || rsp1_valid) begin
        checks++;
        assert ((rsp0_valid & rsp1_valid) === 1'b0) else begin
          errors++;
          $error("FAIL both_rsp_valid observed=%b%b expected=not both", rsp0_valid, rsp1_valid);
        end
      end
      if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
        mon_own  = rsp1_valid && rsp1_ready;
        mon_data = mon_own ? rsp1_data : rsp0_data;
`ifdef ALU_SHARE_ILLEGAL_CHECK_EN
        mon_err  = mon_own ? rsp1_err : rsp0_err;
`else
        mon_err  = 1'b0;
`endif
        checks++;
        assert ((q.size() != 0) === 1'b1) else begin
          errors++;
          $error("FAIL unexpected_rsp observed=owner%0d data=%h expected=no response", mon_own, mon_data);
        end
        if (q.size() != 0) begin
          mon_exp = q.pop_front();
          checks++;
          assert (mon_own === mon_exp.owner) else begin
            errors++;
            $error("FAIL rsp_owner observed=%0d expected=%0d", mon_own, mon_exp.owner);
          end
          checks++;
          assert (mon_data === mon_exp.data) else begin
            errors++;
            $error("FAIL rsp_data observed=%h expected=%h", mon_data, mon_exp.data);
          end
          checks++;
          assert (mon_err === mon_exp.err) else begin
            errors++;
            $error("FAIL rsp_err observed=%b expected=%b", mon_err, mon_exp.err);
          end
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int idx, input logic [31:0] a, input logic [31:0] b,
                         input logic s, input logic [5:0] f);
    if (idx == 1) begin
      req1_a = a; req1_b = b; req1_sign = s; req1_fun = f; req1_valid = 1'b1;
    end else begin
      req0_a = a; req0_b = b; req0_sign = s; req0_fun = f; req0_valid = 1'b1;
    end
  endtask

  task automatic expect_rsp(input logic own, input logic [31:0] d, input logic e);
    exp_t x;
    x.owner = own; x.data = d; x.err = e;
    q.push_back(x);
  endtask

  task automatic wait_ready(input int idx, input string tag);
    int   n;
    logic r;
    n = 0;
    @(negedge clk);
    r = (idx == 1) ? req1_ready : req0_ready;
    while (!r && n < 20) begin
      @(negedge clk);
      n++;
      r = (idx == 1) ? req1_ready : req0_ready;
    end
    chk(tag, {31'b0, r}, 32'd1);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk(tag, q.size(), 32'd0);
  endtask

  task automatic do_op(input int idx, input logic [31:0] a, input logic [31:0] b, input logic s,
                       input logic [5:0] f, input logic [31:0] d, input logic e, input string tag);
    @(posedge clk); #1;
    set_req(idx, a, b, s, f);
    expect_rsp(idx == 1, d, e);
    wait_ready(idx, tag);
    @(posedge clk); #1;
    if (idx == 1) req1_valid = 1'b0; else req0_valid = 1'b0;
    drain(tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req0_ready"}, {31'b0, req0_ready}, 32'd0);
    chk({tag, "_req1_ready"}, {31'b0, req1_ready}, 32'd0);
    chk({tag, "_rsp0_valid"}, {31'b0, rsp0_valid}, 32'd0);
    chk({tag, "_rsp1_valid"}, {31'b0, rsp1_valid}, 32'd0);
    chk({tag, "_rsp0_data"}, rsp0_data, 32'd0);
    chk({tag, "_rsp1_data"}, rsp1_data, 32'd0);
    chk({tag, "_alu_inA"}, alu_inA, 32'd0);
    chk({tag, "_alu_inB"}, alu_inB, 32'd0);
    chk({tag, "_alu_Sign"}, {31'b0, alu_Sign}, 32'd0);
    chk({tag, "_alu_ALUFun"}, {26'b0, alu_ALUFun}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sign = 1'b0; req0_fun = '0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sign = 1'b0; req1_fun = '0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;

    // both requesters valid while reset is held: nothing may be granted
    set_req(0, 32'd10, 32'd3, 1'b0, 6'b000001);
    set_req(1, 32'd4, 32'd1, 1'b0, 6'b100000);
    #12;
    check_all_zero("reset");

    // contention from reset: 0 wins, then 1 beats a still-valid 0, then 0
    expect_rsp(1'b0, 32'd7, 1'b0);
    expect_rsp(1'b1, 32'd16, 1'b0);
    expect_rsp(1'b0, 32'h0000_000F, 1'b0);
    @(posedge clk); #1 reset = 1'b1;
    wait_ready(0, "rr_first_grant0");
    chk("rr_first_no_ready1", {31'b0, req1_ready}, 32'd0);
    @(posedge clk); #1;
    set_req(0, 32'h0000_00FF, 32'h0000_000F, 1'b0, 6'b011000);
    wait_ready(1, "rr_grant1_over_0");
    chk("rr_no_ready0", {31'b0, req0_ready}, 32'd0);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_ready(0, "rr_grant0_again");
    @(posedge clk); #1 req0_valid = 1'b0;
    drain("rr_round_a");

    // last grant was 0, so a simultaneous pair now starts with 1
    @(posedge clk); #1;
    set_req(0, 32'd10, 32'd3, 1'b0, 6'b000001);
    set_req(1, 32'd4, 32'd1, 1'b0, 6'b100000);
    expect_rsp(1'b1, 32'd16, 1'b0);
    expect_rsp(1'b0, 32'd7, 1'b0);
    wait_ready(1, "rr_b_grant1");
    chk("rr_b_no_ready0", {31'b0, req0_ready}, 32'd0);
    @(posedge clk); #1 req1_valid = 1'b0;
    wait_ready(0, "rr_b_grant0");
    @(posedge clk); #1 req0_valid = 1'b0;
    drain("rr_round_b");

    // single op with exact latency and registered ALU drive
    @(posedge clk); #1;
    set_req(0, 32'd5, 32'd7, 1'b1, 6'b000000);
    expect_rsp(1'b0, 32'd12, 1'b0);
    @(negedge clk);
    chk("single_ready", {31'b0, req0_ready}, 32'd1);
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    chk("single_exec_no_valid", {31'b0, rsp0_valid}, 32'd0);
    chk("single_alu_inA", alu_inA, 32'd5);
    chk("single_alu_inB", alu_inB, 32'd7);
    chk("single_alu_Sign", {31'b0, alu_Sign}, 32'd1);
    chk("single_alu_fun", {26'b0, alu_ALUFun}, 32'd0);
    @(negedge clk);
    chk("single_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    chk("single_rsp1_quiet", {31'b0, rsp1_valid}, 32'd0);
    drain("single");

    // backpressure on requester 1 while requester 0 waits
    @(posedge clk); #1;
    rsp1_ready = 1'b0;
    set_req(1, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b0, 6'b010110);
    expect_rsp(1'b1, 32'h0F0F_F0F0, 1'b0);
    wait_ready(1, "bp_grant1");
    @(posedge clk); #1;
    req1_valid = 1'b0;
    set_req(0, 32'd1, 32'd2, 1'b0, 6'b000000);
    expect_rsp(1'b0, 32'd3, 1'b0);
    @(negedge clk);
    chk("bp_exec_no_ready0", {31'b0, req0_ready}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_rsp1_valid", {31'b0, rsp1_valid}, 32'd1);
      chk("bp_rsp1_data", rsp1_data, 32'h0F0F_F0F0);
      chk("bp_no_ready0", {31'b0, req0_ready}, 32'd0);
    end
    @(posedge clk); #1 rsp1_ready = 1'b1;
    wait_ready(0, "bp_grant0_after");
    @(posedge clk); #1 req0_valid = 1'b0;
    drain("bp");

    // compares
    do_op(0, 32'hFFFF_FFFF, 32'd1, 1'b1, 6'b110101, 32'd1, 1'b0, "lt_signed");
    do_op(0, 32'hFFFF_FFFF, 32'd1, 1'b0, 6'b110101, 32'd0, 1'b0, "lt_unsigned");
    do_op(1, 32'd7, 32'd0, 1'b0, 6'b111111, 32'd1, 1'b0, "gtz_req1");
    do_op(0, 32'd9, 32'd9, 1'b0, 6'b110011, 32'd1, 1'b0, "eq");

    // reset during EXEC: discard, clear outputs, restore first-grant-to-0
    @(posedge clk); #1;
    set_req(0, 32'd1, 32'd1, 1'b0, 6'b000000);
    wait_ready(0, "midrst_grant");
    @(posedge clk); #1;
    reset = 1'b0;
    set_req(0, 32'd10, 32'd3, 1'b0, 6'b000001);
    set_req(1, 32'd4, 32'd1, 1'b0, 6'b100000);
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
    expect_rsp(1'b0, 32'd7, 1'b0);
    expect_rsp(1'b1, 32'd16, 1'b0);
    wait_ready(0, "midrst_grant0_first");
    chk("midrst_no_stale_rsp", {31'b0, rsp0_valid}, 32'd0);
    @(posedge clk); #1 req0_valid = 1'b0;
    wait_ready(1, "midrst_grant1");
    @(posedge clk); #1 req1_valid = 1'b0;
    drain("midrst");

`ifdef ALU_SHARE_ILLEGAL_CHECK_EN
    do_op(0, 32'd5, 32'd6, 1'b0, 6'b000010, 32'd0, 1'b1, "illegal_req0");
    do_op(0, 32'd2, 32'd3, 1'b0, 6'b000000, 32'd5, 1'b0, "legal_after_illegal");
    do_op(1, 32'd5, 32'd6, 1'b0, 6'b111110, 32'd0, 1'b1, "illegal_req1");
`endif

    @(posedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
